// File: rtl/fpu_pkg.sv
// Shared encodings and constants for the float-unit issue scheduler.
// Op codes match the decode encoding of in_op.
package fpu_pkg;

   typedef enum logic [2:0] {
      FP_FADD   = 3'd0,
      FP_FSUB   = 3'd1,
      FP_FMUL   = 3'd2,
      FP_FMADD  = 3'd3,
      FP_FMSUB  = 3'd4,
      FP_FNMSUB = 3'd5,
      FP_FNMADD = 3'd6,
      FP_RSVD   = 3'd7
   } fp_op_e;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] NEG_ZERO  = 32'h8000_0000;
   localparam int unsigned SIGN_BIT  = 31;

   // Ops that bypass fmul and go straight to the fadd pipeline
   function automatic logic is_add_path(input fp_op_e op);
      return (op == FP_FADD) || (op == FP_FSUB) || (op == FP_RSVD);
   endfunction

endpackage

// File: rtl/fpu_sched_fifo.sv
// Small synchronous FIFO with first-word-fall-through read.
// Push when full and pop when empty are ignored.
module fpu_sched_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign empty  = (r_cnt == '0);
   assign full   = (r_cnt == CW'(DEPTH));
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
         if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/fpu_fma_sched.sv
// Issue scheduler for the shared fmul/fadd pipelines: sign rewrites, fused-op
// sequencing (fmul then fadd), fadd arbitration and tagged result return.
module fpu_fma_sched #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_rs1,
   input  logic [WIDTH-1:0] in_rs2,
   input  logic [WIDTH-1:0] in_rs3,
   input  logic [TAG_W-1:0] in_tag,
   output logic             mul_valid,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_y,
   output logic             add_valid,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic             add_done,
   input  logic [WIDTH-1:0] add_y,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             err
);

   import fpu_pkg::*;

   localparam int unsigned IW  = $clog2(DEPTH + 1);
   localparam int unsigned MQW = WIDTH + TAG_W;

   fp_op_e           w_op;
   logic             w_add_path;
   logic             w_accept;
   logic [WIDTH-1:0] w_rs1, w_rs2, w_rs3;

   logic             r_mul_valid, r_add_valid, r_out_valid, r_err;
   logic [WIDTH-1:0] r_mul_a, r_mul_b, r_mul_addend, r_add_a, r_add_b, r_out_data;
   logic [TAG_W-1:0] r_mul_tag, r_add_tag, r_out_tag;
   logic [IW-1:0]    r_inflight;

   logic [MQW-1:0]   w_mulq_dout;
   logic             w_mulq_empty, w_mulq_full, w_mulq_pop;
   logic [TAG_W-1:0] w_addq_dout;
   logic             w_addq_empty, w_addq_full, w_addq_pop;

   assign w_op       = fp_op_e'(in_op);
   assign w_add_path = is_add_path(w_op);
   // Add-path ops hold off while a fused second stage claims next cycle's fadd slot
   assign in_ready   = (r_inflight < IW'(DEPTH)) && !(w_add_path && mul_done);
   assign w_accept   = in_valid && in_ready;
   assign w_mulq_pop = mul_done && !w_mulq_empty;
   assign w_addq_pop = add_done && !w_addq_empty;

   // rs3 doubles as the addend; FMUL uses -0 so the fadd pass is exact for +0
   always_comb begin
      w_rs1 = in_rs1;
      w_rs2 = in_rs2;
      w_rs3 = in_rs3;
      case (w_op)
         FP_FSUB:   w_rs2[SIGN_BIT] = ~in_rs2[SIGN_BIT];
         FP_FMUL:   w_rs3 = WIDTH'(NEG_ZERO);
         FP_FMSUB:  w_rs3[SIGN_BIT] = ~in_rs3[SIGN_BIT];
         FP_FNMSUB: w_rs1[SIGN_BIT] = ~in_rs1[SIGN_BIT];
         FP_FNMADD: begin
            w_rs1[SIGN_BIT] = ~in_rs1[SIGN_BIT];
            w_rs3[SIGN_BIT] = ~in_rs3[SIGN_BIT];
         end
         FP_RSVD: begin
            w_rs1 = WIDTH'(CANON_NAN);
            w_rs2 = WIDTH'(CANON_NAN);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_valid  <= 1'b0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_mul_addend <= '0;
         r_mul_tag    <= '0;
         r_add_valid  <= 1'b0;
         r_add_a      <= '0;
         r_add_b      <= '0;
         r_add_tag    <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_tag    <= '0;
         r_err        <= 1'b0;
         r_inflight   <= '0;
      end else begin
         r_mul_valid <= 1'b0;
         r_add_valid <= 1'b0;
         r_out_valid <= 1'b0;
         if (w_accept) begin
            if (w_add_path) begin
               r_add_valid <= 1'b1;
               r_add_a     <= w_rs1;
               r_add_b     <= w_rs2;
               r_add_tag   <= in_tag;
            end else begin
               r_mul_valid  <= 1'b1;
               r_mul_a      <= w_rs1;
               r_mul_b      <= w_rs2;
               r_mul_addend <= w_rs3;
               r_mul_tag    <= in_tag;
            end
         end
         // Fused second stage wins the fadd slot over any direct add
         if (w_mulq_pop) begin
            r_add_valid <= 1'b1;
            r_add_a     <= mul_y;
            r_add_b     <= w_mulq_dout[MQW-1:TAG_W];
            r_add_tag   <= w_mulq_dout[TAG_W-1:0];
         end
         if (w_addq_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= add_y;
            r_out_tag   <= w_addq_dout;
         end
         if ((mul_done && w_mulq_empty) || (add_done && w_addq_empty)) r_err <= 1'b1;
         case ({w_accept, w_addq_pop})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   fpu_sched_fifo #(.DEPTH(DEPTH), .W(MQW)) u_mul_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_mul_valid && !w_mulq_full),
      .din   ({r_mul_addend, r_mul_tag}),
      .pop   (w_mulq_pop),
      .dout  (w_mulq_dout),
      .empty (w_mulq_empty),
      .full  (w_mulq_full)
   );

   fpu_sched_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_add_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_add_valid && !w_addq_full),
      .din   (r_add_tag),
      .pop   (w_addq_pop),
      .dout  (w_addq_dout),
      .empty (w_addq_empty),
      .full  (w_addq_full)
   );

   assign mul_valid = r_mul_valid;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign add_valid = r_add_valid;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;
   assign err       = r_err;

endmodule

// File: tb/tb_fpu_fma_sched.sv
// Directed bench for fpu_fma_sched with 2-cycle fmul/fadd behavioural models.
// Each test task drives its scenario and checks hand-computed results inline.
module tb_fpu_fma_sched;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_rs1, in_rs2, in_rs3;
   logic [TAG_W-1:0] in_tag;
   logic             mul_valid, mul_done, add_valid, add_done, out_valid, err;
   logic [WIDTH-1:0] mul_a, mul_b, mul_y, add_a, add_b, add_y, out_data;
   logic [TAG_W-1:0] out_tag;
   logic             inj_add_done;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   fpu_fma_sched #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_tag(in_tag),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_y(mul_y),
      .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
      .add_done(add_done), .add_y(add_y),
      .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .err(err)
   );

   // Single-precision helpers for normal numbers and zeros (all the bench uses)
   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'h00) d = {x[31], 63'b0};
      else d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:52] == 11'h000) return {d[63], 31'b0};
      return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
   endfunction

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
      return r2sp(sp2r(a) * sp2r(b));
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
      return r2sp(sp2r(a) + sp2r(b));
   endfunction

   logic m1_v, m2_v, a1_v, a2_v;
   logic [31:0] m1_y, m2_y, a1_y, a2_y;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1_v <= 1'b0; m2_v <= 1'b0; a1_v <= 1'b0; a2_v <= 1'b0;
         m1_y <= '0;   m2_y <= '0;   a1_y <= '0;   a2_y <= '0;
      end else begin
         m1_v <= mul_valid; m1_y <= fmul(mul_a, mul_b);
         m2_v <= m1_v;      m2_y <= m1_y;
         a1_v <= add_valid; a1_y <= fadd(add_a, add_b);
         a2_v <= a1_v;      a2_y <= a1_y;
      end
   end

   assign mul_done = m2_v;
   assign mul_y    = m2_y;
   assign add_done = a2_v | inj_add_done;
   assign add_y    = a2_y;

   logic [TAG_W+WIDTH-1:0] res_q[$];
   always @(negedge clk) if (rst_n && out_valid) res_q.push_back({out_tag, out_data});

   // Drive an op from posedge+1 until accepted; returns after the accept edge (+1)
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [3:0] tag, output int stalls);
      bit done;
      in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_tag = tag;
      stalls = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1; else stalls++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: op %0d tag %0d not accepted, required accept within 40 cycles", op, tag);
      end
   endtask

   task automatic wait_result(output logic [TAG_W+WIDTH-1:0] r, output bit ok);
      ok = 0; r = '0;
      for (int i = 0; i < 80 && !ok; i++) begin
         if (res_q.size() > 0) begin r = res_q.pop_front(); ok = 1; end
         else @(negedge clk);
      end
   endtask

   task automatic wait_mul_done(output bit ok);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (mul_done) ok = 1;
      end
   endtask

   task automatic test_reset;
      logic [6*WIDTH+TAG_W+4-1:0] outs;
      rst_n = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
      in_tag = '0; inj_add_done = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      outs = {mul_valid, mul_a, mul_b, add_valid, add_a, add_b, out_valid, out_data, out_tag, err};
      n_checks++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h required 0", outs);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_fused;
      logic [2:0]  ops   [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
      logic [31:0] exp_a [4] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'hC000_0000};
      logic [31:0] exp_c [4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000};
      logic [31:0] exp_p [4] = '{32'h40C0_0000, 32'h40C0_0000, 32'hC0C0_0000, 32'hC0C0_0000};
      logic [31:0] exp_y [4] = '{32'h40E0_0000, 32'h40A0_0000, 32'hC0A0_0000, 32'hC0E0_0000};
      logic [TAG_W+WIDTH-1:0] r;
      bit ok;
      int st;
      for (int k = 0; k < 4; k++) begin
         send(ops[k], 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4'(k + 2), st);
         @(negedge clk);
         n_checks++;
         if ({mul_valid, mul_a, mul_b} !== {1'b1, exp_a[k], 32'h4040_0000}) begin
            n_fail++;
            $display("FAIL fused_mul_issue op%0d: got v=%b a=%h b=%h required v=1 a=%h b=40400000",
                     ops[k], mul_valid, mul_a, mul_b, exp_a[k]);
         end
         wait_mul_done(ok);
         @(negedge clk);
         n_checks++;
         if (!ok || {add_valid, add_a, add_b} !== {1'b1, exp_p[k], exp_c[k]}) begin
            n_fail++;
            $display("FAIL fused_add_issue op%0d: got v=%b a=%h b=%h required v=1 a=%h b=%h",
                     ops[k], add_valid, add_a, add_b, exp_p[k], exp_c[k]);
         end
         wait_result(r, ok);
         n_checks++;
         if (!ok || r !== {4'(k + 2), exp_y[k]}) begin
            n_fail++;
            $display("FAIL fused_result op%0d: got tag/data %h (seen=%0d) required %h",
                     ops[k], r, ok, {4'(k + 2), exp_y[k]});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_add_path;
      logic [TAG_W+WIDTH-1:0] r;
      bit ok;
      int st;
      send(3'd2, 32'h0000_0000, 32'h3F80_0000, 32'h1234_5678, 4'd5, st);
      wait_result(r, ok);
      n_checks++;
      if (!ok || r !== {4'd5, 32'h0000_0000}) begin
         n_fail++; $display("FAIL fmul_pos_zero: got %h required %h", r, {4'd5, 32'h0});
      end
      @(posedge clk); #1;
      send(3'd1, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 4'd6, st);
      @(negedge clk);
      n_checks++;
      if ({add_valid, add_a, add_b} !== {1'b1, 32'h3F80_0000, 32'hBF80_0000}) begin
         n_fail++;
         $display("FAIL fsub_issue: got v=%b a=%h b=%h required v=1 a=3f800000 b=bf800000",
                  add_valid, add_a, add_b);
      end
      wait_result(r, ok);
      n_checks++;
      if (!ok || r !== {4'd6, 32'h0000_0000}) begin
         n_fail++; $display("FAIL fsub_zero: got %h required %h", r, {4'd6, 32'h0});
      end
      @(posedge clk); #1;
      send(3'd7, 32'h3F80_0000, 32'h4000_0000, 32'h0, 4'd7, st);
      @(negedge clk);
      n_checks++;
      if ({add_valid, add_a, add_b} !== {1'b1, 32'h7FC0_0000, 32'h7FC0_0000}) begin
         n_fail++;
         $display("FAIL rsvd_issue: got v=%b a=%h b=%h required v=1 a=b=7fc00000",
                  add_valid, add_a, add_b);
      end
      wait_result(r, ok);
      n_checks++;
      if (!ok || r !== {4'd7, 32'h7FC0_0000}) begin
         n_fail++; $display("FAIL rsvd_nan: got %h required %h", r, {4'd7, 32'h7FC0_0000});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      logic [TAG_W+WIDTH-1:0] r;
      bit ok;
      int st;
      send(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4'd9, st);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (mul_done) ok = 1;
      end
      in_valid = 1'b1; in_op = 3'd0; in_rs1 = 32'h3F80_0000; in_rs2 = 32'h3F80_0000;
      in_rs3 = '0; in_tag = 4'd10;
      #1;
      n_checks++;
      if (!ok || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_ready: got %b (mul_done seen=%0d) required 0", in_ready, ok);
      end
      send(3'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 4'd10, st);
      n_checks++;
      if (st != 1) begin
         n_fail++; $display("FAIL stall_cycles: got %0d required 1", st);
      end
      wait_result(r, ok);
      n_checks++;
      if (!ok || r !== {4'd9, 32'h40E0_0000}) begin
         n_fail++; $display("FAIL stall_first: got %h required %h", r, {4'd9, 32'h40E0_0000});
      end
      wait_result(r, ok);
      n_checks++;
      if (!ok || r !== {4'd10, 32'h4000_0000}) begin
         n_fail++; $display("FAIL stall_second: got %h required %h", r, {4'd10, 32'h4000_0000});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [TAG_W+WIDTH-1:0] r;
      bit ok;
      int st, total;
      total = 0;
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         send(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4'(i + 1), st);
         total += st;
      end
      n_checks++;
      if (total != 3) begin
         n_fail++; $display("FAIL b2b_stall_cycles: got %0d required 3", total);
      end
      for (int i = 0; i < int'(DEPTH) + 2; i++) begin
         wait_result(r, ok);
         n_checks++;
         if (!ok || r !== {4'(i + 1), 32'h40E0_0000}) begin
            n_fail++; $display("FAIL b2b_result_%0d: got %h required %h", i, r, {4'(i + 1), 32'h40E0_0000});
         end
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (res_q.size() != 0 || err !== 1'b0) begin
         n_fail++; $display("FAIL b2b_clean: got extra=%0d err=%b required extra=0 err=0", res_q.size(), err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight;
      logic [6*WIDTH+TAG_W+4-1:0] outs;
      int st;
      res_q.delete();
      send(3'd3, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 4'd11, st);
      send(3'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 4'd12, st);
      send(3'd2, 32'h4000_0000, 32'h4040_0000, 32'h0, 4'd13, st);
      rst_n = 1'b0;
      #1;
      outs = {mul_valid, mul_a, mul_b, add_valid, add_a, add_b, out_valid, out_data, out_tag, err};
      n_checks++;
      if (outs !== '0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h required 0", outs);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      res_q.delete();
      repeat (20) @(negedge clk);
      n_checks++;
      if (res_q.size() != 0 || in_ready !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_quiet: got results=%0d ready=%b err=%b required 0/1/0",
                  res_q.size(), in_ready, err);
      end
      @(posedge clk); #1 inj_add_done = 1'b1;
      @(posedge clk); #1 inj_add_done = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || res_q.size() != 0) begin
         n_fail++; $display("FAIL underflow_err: got err=%b results=%0d required err=1 results=0", err, res_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_fused();
      test_add_path();
      test_stall();
      test_back_to_back();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
